leaf_out_arbiter: RTL and testbench

//  Round-robin arbiter that shares one leaf-interface user->interface port

---
 rtl/leaf_out_arbiter_if.sv | 28 ++
 rtl/leaf_out_arbiter.sv | 123 ++++++++++++
 tb/tb_leaf_out_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_out_arbiter_if.sv
// rtl/leaf_out_arbiter_if.sv - user-stream and interface-side signals of the leaf output arbiter
interface leaf_out_arbiter_if #(
  parameter int NUM_PORTS    = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int PORT_BITS    = 4
);
  logic                              pause;
  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_PORTS-1:0]              vld_user;
  logic [NUM_PORTS-1:0]              ack_arb2user;
  logic [PAYLOAD_BITS-1:0]           dout_arb2intf;
  logic [PORT_BITS-1:0]              port_arb2intf;
  logic                              vld_arb2intf;
  logic                              ack_intf2arb;
  logic [PORT_BITS-1:0]              grant_port;
  logic                              busy;

  // master: the environment (user kernels and leaf interface); slave: the arbiter
  modport master (
    output pause, din_user, vld_user, ack_intf2arb,
    input  ack_arb2user, dout_arb2intf, port_arb2intf, vld_arb2intf, grant_port, busy
  );

  modport slave (
    input  pause, din_user, vld_user, ack_intf2arb,
    output ack_arb2user, dout_arb2intf, port_arb2intf, vld_arb2intf, grant_port, busy
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - burst round-robin arbiter sharing one leaf output port among user streams
module leaf_out_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int PORT_BITS    = 4,
  parameter int BURST_LEN    = 8
) (
  input  logic              clk,
  input  logic              reset,
  leaf_out_arbiter_if.slave bus
);
  localparam int CNT_BITS = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [PORT_BITS-1:0]    grant_r;
  logic [PORT_BITS-1:0]    port_r;
  logic [PORT_BITS-1:0]    next_grant;
  logic [CNT_BITS-1:0]     beat_cnt;
  logic [PAYLOAD_BITS-1:0] dout_r;
  logic [PAYLOAD_BITS-1:0] g_word;
  logic                    vld_r;
  logic                    g_vld;
  logic                    any_vld;
  logic                    space;
  logic                    accept;
  logic [NUM_PORTS-1:0]    ack;

  always_comb begin
    g_vld  = 1'b0;
    g_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_r == PORT_BITS'(i)) begin
        g_vld  = bus.vld_user[i];
        g_word = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // Rotating priority: lowest requester above the last grant wins, else wrap to the lowest overall.
  always_comb begin
    logic                 found_hi;
    logic                 found_lo;
    logic [PORT_BITS-1:0] hi;
    logic [PORT_BITS-1:0] lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi       = grant_r;
    lo       = grant_r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.vld_user[i]) begin
        if (PORT_BITS'(i) > grant_r && !found_hi) begin
          hi       = PORT_BITS'(i);
          found_hi = 1'b1;
        end
        if (PORT_BITS'(i) <= grant_r && !found_lo) begin
          lo       = PORT_BITS'(i);
          found_lo = 1'b1;
        end
      end
    end
    next_grant = found_hi ? hi : lo;
  end

  assign any_vld = |bus.vld_user;
  assign space   = !vld_r || bus.ack_intf2arb;
  assign accept  = !reset && (state == BURST) && g_vld && space && !bus.pause;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ack[i] = accept && (grant_r == PORT_BITS'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vld_r    <= 1'b0;
      dout_r   <= '0;
      port_r   <= '0;
      grant_r  <= PORT_BITS'(NUM_PORTS - 1);
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        dout_r <= g_word;
        port_r <= grant_r;
        vld_r  <= 1'b1;
      end else if (bus.ack_intf2arb) begin
        vld_r  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!bus.pause && any_vld) begin
            grant_r  <= next_grant;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_BITS'(1);
            if (beat_cnt == CNT_BITS'(BURST_LEN - 1)) begin
              state <= IDLE;
            end
          end else if (!g_vld && !bus.pause) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack_arb2user  = ack;
  assign bus.dout_arb2intf = dout_r;
  assign bus.port_arb2intf = port_r;
  assign bus.vld_arb2intf  = vld_r;
  assign bus.grant_port    = grant_r;
  assign bus.busy          = (state == BURST) || vld_r;
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - scoreboard bench for leaf_out_arbiter
module tb_leaf_out_arbiter;
  localparam int NP = 4;
  localparam int PB = 32;
  localparam int TW = 4;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_out_arbiter_if #(.NUM_PORTS(NP), .PAYLOAD_BITS(PB), .PORT_BITS(TW)) bus ();

  leaf_out_arbiter #(.NUM_PORTS(NP), .PAYLOAD_BITS(PB), .PORT_BITS(TW), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [PB-1:0]    src_mem [NP][64];
  int               src_len [NP];
  int               src_pos [NP];
  logic [NP-1:0]    hold;
  logic             sink_ready;
  logic             pause_r;
  logic [TW+PB-1:0] exp_q [$];
  logic [TW+PB-1:0] mon_exp;

  logic [NP-1:0] last_ack;
  logic [PB-1:0] last_dout;
  logic [TW-1:0] last_port;
  logic [TW-1:0] last_grant;
  logic          last_vld;
  logic          last_busy;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_vec++;
      if (!$onehot0(bus.ack_arb2user)) begin
        n_err++;
        $display("FAIL ack_onehot: ack_arb2user=%b, required at most one bit", bus.ack_arb2user);
      end
      if (bus.vld_arb2intf && bus.ack_intf2arb) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got port %0d data %h, required no word", bus.port_arb2intf, bus.dout_arb2intf);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.port_arb2intf, bus.dout_arb2intf} !== mon_exp) begin
            n_err++;
            $display("FAIL sb_word: got port %0d data %h, required port %0d data %h",
                     bus.port_arb2intf, bus.dout_arb2intf, mon_exp[TW+PB-1:PB], mon_exp[PB-1:0]);
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      if (src_pos[i] < src_len[i] && !hold[i]) begin
        bus.vld_user[i] = 1'b1;
        bus.din_user[i*PB +: PB] = src_mem[i][src_pos[i]];
      end else begin
        bus.vld_user[i] = 1'b0;
        bus.din_user[i*PB +: PB] = '0;
      end
    end
    bus.pause        = pause_r;
    bus.ack_intf2arb = sink_ready;
  endtask

  task automatic step();
    @(negedge clk);
    last_ack   = bus.ack_arb2user;
    last_dout  = bus.dout_arb2intf;
    last_port  = bus.port_arb2intf;
    last_grant = bus.grant_port;
    last_vld   = bus.vld_arb2intf;
    last_busy  = bus.busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (last_ack[i]) src_pos[i]++;
    drive();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    hold       = '0;
    pause_r    = 1'b0;
    sink_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic load(input int p, input int n, input logic [PB-1:0] base);
    for (int k = 0; k < n; k++) src_mem[p][k] = base + PB'(k);
    src_len[p] = n;
    src_pos[p] = 0;
  endtask

  task automatic expect_words(input int p, input int first, input int count, input logic [PB-1:0] base);
    for (int k = first; k < first + count; k++) exp_q.push_back({TW'(p), base + PB'(k)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_sources();
    drive();
    repeat (2) step();
    reset = 1'b0;
    drive();
  endtask

  task automatic wait_acks(input string name, input int p, input int count, input int budget);
    int got = 0;
    int n = 0;
    while (got < count && n < budget) begin
      step();
      n++;
      if (last_ack[p]) got++;
    end
    n_vec++;
    if (got != count) begin
      n_err++;
      $display("FAIL %s_wait: port %0d got %0d acks in %0d cycles, required %0d", name, p, got, n, count);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), n);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_sources();
    for (int p = 0; p < NP; p++) load(p, 1, 32'h100 + PB'(p));
    drive();
    repeat (4) step();
    n_vec++;
    if (last_ack !== '0 || last_vld !== 1'b0 || last_busy !== 1'b0 || last_grant !== TW'(NP - 1)) begin
      n_err++;
      $display("FAIL reset_state: ack=%b vld=%b busy=%b grant=%0d, required 0 0 0 %0d",
               last_ack, last_vld, last_busy, last_grant, NP - 1);
    end
    for (int p = 0; p < NP; p++) expect_words(p, 0, 1, 32'h100 + PB'(p));
    reset = 1'b0;
    drive();
    step();
    step();
    n_vec++;
    if (last_grant !== TW'(0) || last_ack !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: grant=%0d ack=%b, required 0 0001", last_grant, last_ack);
    end
    drain("reset", 60);
  endtask

  task automatic test_single_port();
    logic [12:0] pat = '0;
    do_reset();
    load(2, 10, 32'hA0);
    expect_words(2, 0, 10, 32'hA0);
    drive();
    for (int s = 0; s < 13; s++) begin
      step();
      pat = {pat[11:0], last_ack[2]};
    end
    n_vec++;
    if (pat !== 13'b0111111110110) begin
      n_err++;
      $display("FAIL single_burst_pattern: ack[2] sequence %b, required %b", pat, 13'b0111111110110);
    end
    drain("single", 40);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NP; p++) load(p, 16, PB'(p + 1) << 28);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) expect_words(p, r * BL, BL, PB'(p + 1) << 28);
    drive();
    drain("round_robin", 200);
  endtask

  task automatic test_sink_stall();
    do_reset();
    load(1, 10, 32'hB0);
    expect_words(1, 0, 10, 32'hB0);
    drive();
    wait_acks("stall", 1, 3, 20);
    sink_ready = 1'b0;
    drive();
    for (int s = 0; s < 5; s++) begin
      step();
      n_vec++;
      if (last_ack !== '0 || last_vld !== 1'b1 || last_dout !== 32'hB2 || last_port !== TW'(1)) begin
        n_err++;
        $display("FAIL stall_hold%0d: ack=%b vld=%b dout=%h port=%0d, required 0000 1 000000b2 1",
                 s, last_ack, last_vld, last_dout, last_port);
      end
    end
    sink_ready = 1'b1;
    drive();
    drain("stall", 60);
  endtask

  task automatic test_pause();
    logic [5:0] pat = '0;
    do_reset();
    load(1, 12, 32'hC0);
    expect_words(1, 0, 12, 32'hC0);
    drive();
    wait_acks("pause", 1, 3, 20);
    pause_r = 1'b1;
    drive();
    for (int s = 0; s < 4; s++) begin
      step();
      n_vec++;
      if (last_ack !== '0 || last_grant !== TW'(1) || (s > 0 && last_vld !== 1'b0)) begin
        n_err++;
        $display("FAIL pause_hold%0d: ack=%b grant=%0d vld=%b, required 0000 1 %0d",
                 s, last_ack, last_grant, last_vld, (s > 0) ? 0 : 1);
      end
    end
    pause_r = 1'b0;
    drive();
    for (int s = 0; s < 6; s++) begin
      step();
      pat = {pat[4:0], last_ack[1]};
    end
    n_vec++;
    if (pat !== 6'b111110) begin
      n_err++;
      $display("FAIL pause_resume_beats: ack[1] sequence %b, required 111110", pat);
    end
    drain("pause", 60);
  endtask

  task automatic test_gap_and_reset();
    do_reset();
    load(3, 3, 32'hD0);
    load(0, 10, 32'hE0);
    hold[0] = 1'b1;
    expect_words(3, 0, 3, 32'hD0);
    expect_words(0, 0, 10, 32'hE0);
    drive();
    step();
    hold[0] = 1'b0;
    drive();
    wait_acks("gap", 3, 3, 20);
    step();
    step();
    step();
    n_vec++;
    if (last_grant !== TW'(0) || last_ack !== 4'b0001) begin
      n_err++;
      $display("FAIL gap_regrant: grant=%0d ack=%b, required 0 0001", last_grant, last_ack);
    end
    step();
    reset = 1'b1;
    exp_q.delete();
    drive();
    step();
    n_vec++;
    if (last_ack !== '0) begin
      n_err++;
      $display("FAIL reset_ack_gate: ack=%b, required 0000", last_ack);
    end
    step();
    n_vec++;
    if (last_vld !== 1'b0 || last_dout !== '0 || last_port !== '0 || last_grant !== TW'(NP - 1) || last_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midburst_reset: vld=%b dout=%h port=%0d grant=%0d busy=%b, required 0 0 0 %0d 0",
               last_vld, last_dout, last_port, last_grant, last_busy, NP - 1);
    end
    clear_sources();
    reset = 1'b0;
    drive();
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_sources();
    drive();
    test_reset();
    test_single_port();
    test_round_robin();
    test_sink_stall();
    test_pause();
    test_gap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
